alu_mdu: RTL and testbench
==========================

ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter DATAWIDTH, default 32, operand/result width; SHALL be a power of two, >= 8.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 valid_i  input  1  operation request valid.
REQ-005 SrcA_i  input  DATAWIDTH  operand A.
REQ-006 SrcB_i  input  DATAWIDTH  operand B.
REQ-007 ALUctrl_i  input  5  operation select (REQ-012).
REQ-008 ready_o  output  1  block can accept a request this cycle.
REQ-009 valid_o  output  1  one-cycle pulse: ALUResult_o/Zero_o carry a new result.
REQ-010 ALUResult_o  output  DATAWIDTH  registered result, held until next result.
REQ-011 Zero_o  output  1  registered, equals (ALUResult_o == 0).

Function
REQ-012 Ops: 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR, 00101 SLT (signed), 00110 SLTU, 00111 SLL, 01000 SRL, 01001 SRA, 10000 MUL (low half), 10001 MULHU (high half, unsigned), 10100 DIVU, 10101 REMU; any other code SHALL produce result 0 with single-cycle latency.
REQ-013 Accept: request taken on a rising edge where valid_i=1 and ready_o=1; valid_i while ready_o=0 SHALL be ignored, no state change.
REQ-014 ADD/SUB SHALL wrap modulo 2^DATAWIDTH; SLT/SLTU SHALL return 1 or 0 zero-extended.
REQ-015 Shifts SHALL use only the low log2(DATAWIDTH) bits of SrcB_i; SRA SHALL replicate SrcA_i MSB.
REQ-016 Single-cycle ops (codes 0xxxx and undefined): accepted on edge k, result registered on edge k and valid_o=1 in the following cycle; ready_o SHALL stay 1, allowing one accept per cycle back-to-back.
REQ-017 Multi-cycle ops (MUL, MULHU, DIVU, REMU): iterative, one partial step per cycle, shift-add multiply and restoring divide; operands latched on accept edge k.
REQ-018 Multi-cycle latency: result registered on edge k+DATAWIDTH, valid_o=1 in the following cycle; latency SHALL be data-independent.
REQ-019 ready_o SHALL be 0 in cycles following edges k through k+DATAWIDTH-1, and 1 again in the cycle valid_o pulses, so a new request may be accepted in that cycle.
REQ-020 State machine: IDLE (ready_o=1) and BUSY (ready_o=0, counter active); IDLE->BUSY on multi-cycle accept; BUSY->IDLE when step counter reaches DATAWIDTH-1; counter width clog2(DATAWIDTH).
REQ-021 Divide by zero: DIVU SHALL return all ones, REMU SHALL return SrcA_i, both with full REQ-018 latency.
REQ-022 ALUResult_o and Zero_o SHALL change only on edges that also raise valid_o; intermediate iteration values SHALL NOT appear on outputs.
REQ-023 valid_o SHALL be 0 in every cycle without a newly completed result.

Reset
REQ-024 While rst=1 on an edge: state->IDLE, counter->0, valid_o->0, ALUResult_o->0, Zero_o->1, ready_o->0 while rst asserted, 1 in the first cycle after rst deasserts.
REQ-025 rst during BUSY SHALL abort the operation; no valid_o SHALL be produced for it.
REQ-026 A request presented on an edge with rst=1 SHALL be discarded.

Verification (DATAWIDTH=32)
REQ-027 ADD 5 + 0xFFFFFFFB -> next cycle valid_o=1, ALUResult_o=0, Zero_o=1; SUB 3-5 next cycle -> 0xFFFFFFFE, Zero_o=0, ready_o constant 1.
REQ-028 MUL 0xFFFFFFFF x 0xFFFFFFFF -> ready_o low 32 cycles, valid_o after edge k+32 with 0x00000001; MULHU same operands -> 0xFFFFFFFE.
REQ-029 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9; each exactly 32-cycle latency.
REQ-030 valid_i held high with ADD during BUSY DIVU -> ADD ignored until ready_o=1; ADD accepted in valid_o cycle yields second valid_o next cycle.
REQ-031 rst pulsed at cycle 10 of DIVU -> no valid_o, outputs 0/Zero_o=1, ready_o=1 after deassert; subsequent SRA 0x80000000 by 0x24 (shift 4) -> 0xF8000000.
REQ-032 SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0; undefined code 11111 -> 0, Zero_o=1, one-cycle latency.

Source files
------------

// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle ALU plus an iterative multiply/divide unit.
// Single-cycle ops complete one cycle after acceptance, back-to-back.
// MUL/MULHU/DIVU/REMU run DATAWIDTH shift-add / restoring-divide steps
// and deliver their result DATAWIDTH cycles after acceptance.
module alu_mdu #(
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic [DATAWIDTH-1:0] SrcA_i,
  input  logic [DATAWIDTH-1:0] SrcB_i,
  input  logic [4:0]           ALUctrl_i,
  output logic                 ready_o,
  output logic                 valid_o,
  output logic [DATAWIDTH-1:0] ALUResult_o,
  output logic                 Zero_o
);

  localparam int unsigned SHW = $clog2(DATAWIDTH);
  localparam logic [SHW-1:0] LAST_STEP = SHW'(DATAWIDTH - 1);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SLT  = 5'b00101;
  localparam logic [4:0] OP_SLTU = 5'b00110;
  localparam logic [4:0] OP_SLL  = 5'b00111;
  localparam logic [4:0] OP_SRL  = 5'b01000;
  localparam logic [4:0] OP_SRA  = 5'b01001;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  // Bit 1 selects divide, bit 0 selects the "other half" (MULHU / REMU).
  typedef enum logic [1:0] {
    MD_MUL   = 2'b00,
    MD_MULHU = 2'b01,
    MD_DIVU  = 2'b10,
    MD_REMU  = 2'b11
  } md_op_e;

  state_e               state_q, state_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  md_op_e               op_q, op_d;
  logic [DATAWIDTH-1:0] acc_q, acc_d;    // mul: high product half; div: remainder
  logic [DATAWIDTH-1:0] sh_q, sh_d;      // mul: multiplier/low half; div: dividend/quotient
  logic [DATAWIDTH-1:0] opnd_q, opnd_d;  // mul: multiplicand; div: divisor
  logic                 valid_q, valid_d;
  logic [DATAWIDTH-1:0] result_q, result_d;
  logic                 zero_q, zero_d;

  logic                 accept;
  logic                 is_multi;
  logic [SHW-1:0]       shamt;
  logic [DATAWIDTH-1:0] alu_res;
  logic [DATAWIDTH:0]   mul_sum, div_tmp, div_diff;
  logic                 div_ge;
  logic [DATAWIDTH-1:0] step_acc, step_sh;

  // ready_o drops during reset so a request on a reset edge is never taken.
  assign ready_o     = (state_q == S_IDLE) && !rst;
  assign accept      = valid_i && ready_o;
  assign is_multi    = (ALUctrl_i ==? 5'b10?0?);
  assign shamt       = SrcB_i[SHW-1:0];
  assign valid_o     = valid_q;
  assign ALUResult_o = result_q;
  assign Zero_o      = zero_q;

  // Single-cycle ALU result; undefined codes yield zero.
  always_comb begin
    // NOTE: a default assignment first keeps every path assigned, so no latch is inferred.
    alu_res = '0;
    case (ALUctrl_i)
      OP_ADD:  alu_res = SrcA_i + SrcB_i;
      OP_SUB:  alu_res = SrcA_i - SrcB_i;
      OP_AND:  alu_res = SrcA_i & SrcB_i;
      OP_OR:   alu_res = SrcA_i | SrcB_i;
      OP_XOR:  alu_res = SrcA_i ^ SrcB_i;
      OP_SLT:  alu_res = {{(DATAWIDTH-1){1'b0}}, ($signed(SrcA_i) < $signed(SrcB_i))};
      OP_SLTU: alu_res = {{(DATAWIDTH-1){1'b0}}, (SrcA_i < SrcB_i)};
      OP_SLL:  alu_res = SrcA_i << shamt;
      OP_SRL:  alu_res = SrcA_i >> shamt;
      OP_SRA:  alu_res = DATAWIDTH'($signed(SrcA_i) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // One shift-add or restoring-divide step on the iteration registers.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : '0);
    div_tmp  = {acc_q, sh_q[DATAWIDTH-1]};
    div_diff = div_tmp - {1'b0, opnd_q};
    div_ge   = (div_tmp >= {1'b0, opnd_q});
    if (op_q[1]) begin
      // Divide by zero falls out naturally: every step subtracts, quotient is all ones
      // and the remainder shifts in the whole dividend.
      step_acc = div_ge ? div_diff[DATAWIDTH-1:0] : div_tmp[DATAWIDTH-1:0];
      step_sh  = {sh_q[DATAWIDTH-2:0], div_ge};
    end else begin
      step_acc = mul_sum[DATAWIDTH:1];
      step_sh  = {mul_sum[0], sh_q[DATAWIDTH-1:1]};
    end
  end

  // Next-state logic: accept in IDLE, iterate in BUSY, publish on completion.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    opnd_d   = opnd_q;
    valid_d  = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_multi) begin
            state_d = S_BUSY;
            cnt_d   = '0;
            op_d    = md_op_e'({ALUctrl_i[2], ALUctrl_i[0]});
            acc_d   = '0;
            sh_d    = ALUctrl_i[2] ? SrcA_i : SrcB_i;
            opnd_d  = ALUctrl_i[2] ? SrcB_i : SrcA_i;
          end else begin
            valid_d  = 1'b1;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
          end
        end
      end
      S_BUSY: begin
        acc_d = step_acc;
        sh_d  = step_sh;
        if (cnt_q == LAST_STEP) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          valid_d  = 1'b1;
          result_d = op_q[0] ? step_acc : step_sh;
          zero_d   = ((op_q[0] ? step_acc : step_sh) == '0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset; a reset mid-operation aborts it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= MD_MUL;
      acc_q    <= '0;
      sh_q     <= '0;
      opnd_q   <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      opnd_q   <= opnd_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed testbench for alu_mdu at DATAWIDTH=32.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [31:0] SrcA_i, SrcB_i;
  logic [4:0]  ALUctrl_i;
  logic        ready_o, valid_o, Zero_o;
  logic [31:0] ALUResult_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_exp;

  alu_mdu #(.DATAWIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .SrcA_i     (SrcA_i),
    .SrcB_i     (SrcB_i),
    .ALUctrl_i  (ALUctrl_i),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .ALUResult_o(ALUResult_o),
    .Zero_o     (Zero_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single-cycle op: accept on the next edge, result visible right after it.
  task automatic do_single(input string tag, input logic [4:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    ALUctrl_i = op; SrcA_i = a; SrcB_i = b; valid_i = 1'b1;
    check({tag, ".ready"}, {31'b0, ready_o}, 32'd1);
    step();
    valid_i = 1'b0;
    check({tag, ".valid"}, {31'b0, valid_o}, 32'd1);
    check({tag, ".result"}, ALUResult_o, exp);
    check({tag, ".zero"}, {31'b0, Zero_o}, {31'b0, (exp == 32'd0)});
    last_exp = exp;
  endtask

  // Multi-cycle op: measure latency and busy cycles, confirm outputs held meanwhile.
  task automatic do_multi(input string tag, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int lat, lows, hold_bad;
    ALUctrl_i = op; SrcA_i = a; SrcB_i = b; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    lat = 0; lows = 0; hold_bad = 0;
    while (valid_o !== 1'b1 && lat < 100) begin
      if (ready_o === 1'b0) lows++;
      if (ALUResult_o !== last_exp) hold_bad++;
      step();
      lat++;
    end
    check({tag, ".latency"}, lat, 32'd32);
    check({tag, ".busy_cycles"}, lows, 32'd32);
    check({tag, ".held"}, hold_bad, 32'd0);
    check({tag, ".result"}, ALUResult_o, exp);
    check({tag, ".zero"}, {31'b0, Zero_o}, {31'b0, (exp == 32'd0)});
    check({tag, ".ready_at_valid"}, {31'b0, ready_o}, 32'd1);
    step();
    check({tag, ".pulse"}, {31'b0, valid_o}, 32'd0);
    last_exp = exp;
  endtask

  initial begin
    int bad;
    rst = 1'b1; valid_i = 1'b0; SrcA_i = '0; SrcB_i = '0; ALUctrl_i = '0;
    last_exp = 32'd0;
    step(); step();
    check("rst.ready", {31'b0, ready_o}, 32'd0);
    check("rst.valid", {31'b0, valid_o}, 32'd0);
    check("rst.result", ALUResult_o, 32'd0);
    check("rst.zero", {31'b0, Zero_o}, 32'd1);
    rst = 1'b0;
    #1;
    check("rst.ready_after", {31'b0, ready_o}, 32'd1);

    // ADD then SUB back-to-back.
    ALUctrl_i = 5'b00000; SrcA_i = 32'd5; SrcB_i = 32'hFFFF_FFFB; valid_i = 1'b1;
    step();
    ALUctrl_i = 5'b00001; SrcA_i = 32'd3; SrcB_i = 32'd5;
    check("add.valid", {31'b0, valid_o}, 32'd1);
    check("add.result", ALUResult_o, 32'd0);
    check("add.zero", {31'b0, Zero_o}, 32'd1);
    check("add.ready", {31'b0, ready_o}, 32'd1);
    step();
    valid_i = 1'b0;
    check("sub.valid", {31'b0, valid_o}, 32'd1);
    check("sub.result", ALUResult_o, 32'hFFFF_FFFE);
    check("sub.zero", {31'b0, Zero_o}, 32'd0);
    check("sub.ready", {31'b0, ready_o}, 32'd1);
    step();
    check("sub.pulse", {31'b0, valid_o}, 32'd0);
    check("sub.held", ALUResult_o, 32'hFFFF_FFFE);
    last_exp = 32'hFFFF_FFFE;

    do_single("and",  5'b00010, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234);
    do_single("or",   5'b00011, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F);
    do_single("xor",  5'b00100, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00);
    do_single("sll",  5'b00111, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002);
    do_single("srl",  5'b01000, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001);
    do_single("slt",  5'b00101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
    do_single("sltu", 5'b00110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    do_single("sra0", 5'b01001, 32'h7000_0000, 32'h0000_0004, 32'h0700_0000);
    do_single("undef31", 5'b11111, 32'h1234_5678, 32'h1, 32'h0);
    do_single("sub1", 5'b00001, 32'd10, 32'd3, 32'd7);
    do_single("undef18", 5'b10010, 32'h1234_5678, 32'h1, 32'h0);

    do_multi("mul",    5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    do_multi("mulhu",  5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_multi("mul16",  5'b10000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
    do_multi("mulhu16",5'b10001, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
    do_multi("divu",   5'b10100, 32'd100, 32'd7, 32'd14);
    do_multi("remu",   5'b10101, 32'd100, 32'd7, 32'd2);
    do_multi("divu0",  5'b10100, 32'd9, 32'd0, 32'hFFFF_FFFF);
    do_multi("remu0",  5'b10101, 32'd9, 32'd0, 32'd9);

    // ADD held on valid_i during a DIVU is taken only in the valid_o cycle.
    ALUctrl_i = 5'b10100; SrcA_i = 32'd100; SrcB_i = 32'd7; valid_i = 1'b1;
    step();
    ALUctrl_i = 5'b00000; SrcA_i = 32'd1; SrcB_i = 32'd2;
    bad = 0;
    for (int i = 1; i < 32; i++) begin
      step();
      if (valid_o !== 1'b0 || ALUResult_o !== last_exp) bad++;
    end
    check("hold_add.ignored", bad, 32'd0);
    step();
    check("hold_add.div_valid", {31'b0, valid_o}, 32'd1);
    check("hold_add.div_result", ALUResult_o, 32'd14);
    check("hold_add.ready", {31'b0, ready_o}, 32'd1);
    step();
    valid_i = 1'b0;
    check("hold_add.add_valid", {31'b0, valid_o}, 32'd1);
    check("hold_add.add_result", ALUResult_o, 32'd3);
    step();
    check("hold_add.pulse", {31'b0, valid_o}, 32'd0);

    // Reset aborts a DIVU; a request on the reset edge is dropped.
    ALUctrl_i = 5'b10100; SrcA_i = 32'd100; SrcB_i = 32'd7; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    repeat (10) step();
    ALUctrl_i = 5'b00000; SrcA_i = 32'd1; SrcB_i = 32'd1; valid_i = 1'b1;
    rst = 1'b1;
    step();
    check("abort.valid", {31'b0, valid_o}, 32'd0);
    check("abort.result", ALUResult_o, 32'd0);
    check("abort.zero", {31'b0, Zero_o}, 32'd1);
    check("abort.ready_in_rst", {31'b0, ready_o}, 32'd0);
    valid_i = 1'b0;
    rst = 1'b0;
    #1;
    check("abort.ready_after", {31'b0, ready_o}, 32'd1);
    bad = 0;
    repeat (40) begin
      step();
      if (valid_o !== 1'b0 || ALUResult_o !== 32'd0) bad++;
    end
    check("abort.quiet", bad, 32'd0);
    last_exp = 32'd0;
    do_single("sra", 5'b01001, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000);
    step();
    check("sra.pulse", {31'b0, valid_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
